spi_reg_slave: RTL and testbench



---
 rtl/spi_reg_slave.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// SPI mode-0 responder exposing a byte-wide register file; every SPI input is oversampled in io_systemClk.
// A frame is a command byte (bit7 = read, low bits = start address) followed by auto-incrementing data bytes, MSB first.
module spi_reg_slave #(
    parameter int NUM_REGS    = 16,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  io_systemClk,
    input  logic                  io_systemReset,
    input  logic                  spi_sclk,
    input  logic                  spi_ss,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic [8*NUM_REGS-1:0] reg_q,
    output logic                  wr_valid,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic                   ss_dly_q, ss_dly_d;

    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shreg_rx_q, shreg_rx_d;
    logic [7:0]             shreg_tx_q, shreg_tx_d;
    logic                   rw_q, rw_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   busy_q, busy_d;
    logic                   wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic [7:0]             regs_q [NUM_REGS];
    logic [7:0]             regs_d [NUM_REGS];

    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise_s, sclk_fall_s, ss_fall_s;
    logic                   last_bit_s;
    logic [7:0]             rx_byte_s;
    logic [ADDR_W-1:0]      cmd_addr_s, addr_inc_s;

    // mosi is taken from the same depth as sclk so each sampled bit lines up with its detected edge
    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s        = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_dly_q;
    assign sclk_fall_s = ~sclk_s & sclk_dly_q;
    assign ss_fall_s   = ~ss_s & ss_dly_q;
    assign last_bit_s  = (bit_cnt_q == 3'd7);
    assign rx_byte_s   = {shreg_rx_q[6:0], mosi_s};
    assign cmd_addr_s  = rx_byte_s[ADDR_W-1:0];
    assign addr_inc_s  = addr_q + ADDR_W'(1);

    assign spi_miso    = miso_q;
    assign spi_miso_oe = miso_oe_q;
    assign wr_valid    = wr_valid_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;

    // Synchroniser chains and edge-detect delay flops
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_ss};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sclk_dly_d  = sclk_s;
        ss_dly_d    = ss_s;
    end

    // Frame FSM: command decode, write commit, read shifter and abort handling
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_rx_d = shreg_rx_q;
        shreg_tx_d = shreg_tx_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;

        case (state_q)
            ST_IDLE: begin
                if (ss_fall_s) begin
                    state_d    = ST_CMD;
                    bit_cnt_d  = 3'd0;
                    shreg_rx_d = 8'h00;
                    busy_d     = 1'b1;
                end else begin
                    busy_d     = 1'b0;
                end
            end

            ST_CMD: begin
                if (ss_s) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    busy_d    = 1'b0;
                end else if (sclk_rise_s) begin
                    shreg_rx_d = rx_byte_s;
                    if (last_bit_s) begin
                        bit_cnt_d = 3'd0;
                        rw_d      = rx_byte_s[7];
                        addr_d    = cmd_addr_s;
                        state_d   = ST_DATA;
                        if (rx_byte_s[7]) begin
                            shreg_tx_d = regs_q[cmd_addr_s];
                            miso_d     = regs_q[cmd_addr_s][7];
                            miso_oe_d  = 1'b1;
                        end else begin
                            miso_oe_d  = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    shreg_rx_d = shreg_rx_q;
                end
            end

            ST_DATA: begin
                // A byte completing on the same cycle ss rises is still committed
                if (sclk_rise_s && last_bit_s && !rw_q) begin
                    regs_d[addr_q] = rx_byte_s;
                    wr_valid_d     = 1'b1;
                    wr_addr_d      = addr_q;
                    wr_data_d      = rx_byte_s;
                end else begin
                    wr_valid_d     = 1'b0;
                end

                if (ss_s) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    busy_d    = 1'b0;
                end else if (sclk_rise_s) begin
                    if (last_bit_s) begin
                        bit_cnt_d  = 3'd0;
                        addr_d     = addr_inc_s;
                        shreg_rx_d = 8'h00;
                        if (rw_q) begin
                            shreg_tx_d = regs_q[addr_inc_s];
                            miso_d     = regs_q[addr_inc_s][7];
                        end else begin
                            shreg_tx_d = shreg_tx_q;
                        end
                    end else begin
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        shreg_rx_d = rx_byte_s;
                    end
                end else if (sclk_fall_s && rw_q && (bit_cnt_q != 3'd0)) begin
                    // the fall right after a byte boundary must keep the freshly loaded MSB
                    shreg_tx_d = {shreg_tx_q[6:0], 1'b0};
                    miso_d     = shreg_tx_q[6];
                end else begin
                    shreg_tx_d = shreg_tx_q;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = 3'd0;
                miso_d    = 1'b0;
                miso_oe_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // Flatten the register file onto the reg_q bus
    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[8*i +: 8] = regs_q[i];
        end
    end

    // State register with synchronous active-high reset
    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            ss_dly_q    <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shreg_rx_q  <= 8'h00;
            shreg_tx_q  <= 8'h00;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            ss_dly_q    <= ss_dly_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_rx_q  <= shreg_rx_d;
            shreg_tx_q  <= shreg_tx_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            busy_q      <= busy_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: a bit-level SPI master, a table of directed frames, hand-written corner sequences
// and random frames, all checked against an array-based model of the register file.
module tb_spi_reg_slave;
    localparam int NR = 16;
    localparam int AW = 4;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sclk = 1'b0;
    logic          ss = 1'b1;
    logic          mosi = 1'b0;
    logic          miso, oe, wr_valid, busy;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [8*NR-1:0] reg_q;

    spi_reg_slave #(.NUM_REGS(NR), .ADDR_W(AW), .SYNC_STAGES(SS)) dut (
        .io_systemClk(clk), .io_systemReset(rst),
        .spi_sclk(sclk), .spi_ss(ss), .spi_mosi(mosi),
        .spi_miso(miso), .spi_miso_oe(oe), .reg_q(reg_q),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          wr_count = 0;
    logic [7:0]  model [NR];
    logic [11:0] exp_q [$];
    logic [7:0]  tx_buf [40];
    logic [7:0]  rx_buf [40];
    logic [7:0]  exp_rx [40];

    typedef struct packed {
        logic [31:0] bytes;
        logic [2:0]  n;
        logic [1:0]  nchk;
        logic [11:0] ca;
        logic [23:0] cv;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [8*NR-1:0] model_flat();
        logic [8*NR-1:0] f;
        for (int i = 0; i < NR; i++) f[8*i +: 8] = model[i];
        return f;
    endfunction

    // Reference: what a frame in tx_buf should do, from the protocol rules alone.
    task automatic model_frame(input int n);
        logic [3:0] a;
        a = tx_buf[0][3:0];
        for (int i = 1; i < n; i++) begin
            if (tx_buf[0][7]) exp_rx[i] = model[a];
            else begin
                model[a] = tx_buf[i];
                exp_q.push_back({a, tx_buf[i]});
            end
            a = a + 4'd1;
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb, input bit ss_at_last,
                            output logic [7:0] rx, output logic oe_and, output logic oe_or);
        rx = 8'h00; oe_and = 1'b1; oe_or = 1'b0;
        for (int i = 0; i < nb; i++) begin
            mosi = tx[7-i];
            tick(4);
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            oe_and = oe_and & oe;
            oe_or = oe_or | oe;
            if (ss_at_last && i == nb - 1) ss = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int n, input int extra_bits, input bit ss_last);
        logic [7:0] rx;
        logic oa, oo;
        ss = 1'b0;
        tick(4);
        for (int b = 0; b < n; b++) begin
            spi_bits(tx_buf[b], 8, ss_last && (b == n - 1), rx, oa, oo);
            rx_buf[b] = rx;
            if (b == 0) begin
                chk("cmd_oe_low", oo, 1'b0);
                if (!ss_last) chk("busy_in_frame", busy, 1'b1);
            end else if (tx_buf[0][7]) chk("rd_oe_high", oa, 1'b1);
            else chk("wr_oe_low", oo, 1'b0);
        end
        if (extra_bits > 0) spi_bits(8'hFF, extra_bits, 1'b0, rx, oa, oo);
        tick(4);
        ss = 1'b1;
        tick(12);
        chk("idle_oe", oe, 1'b0);
        chk("idle_busy", busy, 1'b0);
    endtask

    task automatic check_after(input int n);
        chk("regs_vs_model", reg_q, model_flat());
        if (tx_buf[0][7]) begin
            for (int i = 1; i < n; i++) chk("rd_byte", rx_buf[i], exp_rx[i]);
        end
        chk("wr_queue_drained", exp_q.size(), 0);
    endtask

    // Write monitor: every wr_valid pulse must be one cycle wide and match the next expected write.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) prev = 1'b0;
            else begin
                if (wr_valid) begin
                    wr_count++;
                    chk("wv_single_cycle", prev, 1'b0);
                    chk("wv_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) chk("wv_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
                end
                prev = wr_valid;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rx, old2;
        logic oa, oo;
        int wc0, n, extra;
        bit seen_idle;

        for (int i = 0; i < NR; i++) model[i] = 8'h00;
        vecs[0] = '{bytes: 32'h03A5_0000, n: 3'd2, nchk: 2'd1, ca: 12'h300, cv: 24'hA50000};
        vecs[1] = '{bytes: 32'h0E11_2233, n: 3'd4, nchk: 2'd3, ca: 12'hEF0, cv: 24'h112233};
        vecs[2] = '{bytes: 32'h0F5A_C300, n: 3'd3, nchk: 2'd2, ca: 12'hF00, cv: 24'h5AC300};
        vecs[3] = '{bytes: 32'h8F00_0000, n: 3'd3, nchk: 2'd2, ca: 12'h000, cv: 24'h5AC300};
        vecs[4] = '{bytes: 32'h0500_0000, n: 3'd1, nchk: 2'd1, ca: 12'h500, cv: 24'h000000};
        vecs[5] = '{bytes: 32'h7496_0000, n: 3'd2, nchk: 2'd1, ca: 12'h400, cv: 24'h960000};
        vecs[6] = '{bytes: 32'hF4FF_0000, n: 3'd2, nchk: 2'd1, ca: 12'h000, cv: 24'h960000};

        // Reset with ss low and sclk toggling
        rst = 1'b1; ss = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(1); sclk = ~sclk; end
        chk("reset_outs", {miso, oe, wr_valid, wr_addr, wr_data, busy}, 0);
        chk("reset_regs", reg_q, 0);
        rst = 1'b0; sclk = 1'b0;
        for (int i = 0; i < 16; i++) begin tick(2); sclk = ~sclk; end
        chk("ss_low_at_release_busy", busy, 1'b0);
        chk("ss_low_at_release_oe", oe, 1'b0);
        sclk = 1'b0; ss = 1'b1;
        tick(8);

        // Single write with exact latency: wr_valid appears SYNC_STAGES+1 cycles after the 16th rise
        tx_buf[0] = 8'h03; tx_buf[1] = 8'hA5;
        model_frame(2);
        ss = 1'b0; tick(4);
        spi_bits(8'h03, 8, 1'b0, rx, oa, oo);
        spi_bits(8'hA5, 7, 1'b0, rx, oa, oo);
        mosi = 1'b1; tick(4); sclk = 1'b1;
        tick(1); chk("lat_c1_wv", wr_valid, 1'b0);
        tick(1); chk("lat_c2_wv", wr_valid, 1'b0); chk("lat_c2_reg", reg_q[31:24], 8'h00);
        tick(1); chk("lat_c3_wv", wr_valid, 1'b1); chk("lat_c3_reg", reg_q[31:24], 8'hA5);
        chk("lat_c3_addr_data", {wr_addr, wr_data}, 12'h3A5);
        tick(1); chk("lat_c4_wv", wr_valid, 1'b0);
        chk("single_oe", oe, 1'b0);
        tick(3); sclk = 1'b0; tick(4); ss = 1'b1; tick(12);
        check_after(2);

        // Directed table
        for (int v = 0; v < 7; v++) begin
            for (int j = 0; j < 4; j++) tx_buf[j] = vecs[v].bytes[31-8*j -: 8];
            model_frame(int'(vecs[v].n));
            run_frame(int'(vecs[v].n), 0, 1'b0);
            check_after(int'(vecs[v].n));
            for (int j = 0; j < int'(vecs[v].nchk); j++) begin
                if (vecs[v].bytes[31]) chk("vec_rd", rx_buf[j+1], vecs[v].cv[23-8*j -: 8]);
                else chk("vec_wr", reg_q[8*vecs[v].ca[11-4*j -: 4] +: 8], vecs[v].cv[23-8*j -: 8]);
            end
        end

        // Abort after 5 data bits: no write, busy drops quickly, next frame writes normally
        old2 = model[2];
        tx_buf[0] = 8'h02;
        model_frame(1);
        ss = 1'b0; tick(4);
        spi_bits(8'h02, 8, 1'b0, rx, oa, oo);
        spi_bits(8'hFF, 5, 1'b0, rx, oa, oo);
        ss = 1'b1;
        seen_idle = 1'b0;
        for (int c = 0; c < SS + 2 && !seen_idle; c++) begin
            tick(1);
            if (!busy) seen_idle = 1'b1;
        end
        chk("abort_busy_drop", seen_idle, 1'b1);
        tick(12);
        chk("abort_reg2_kept", reg_q[23:16], old2);
        check_after(1);
        tx_buf[0] = 8'h02; tx_buf[1] = 8'h7E;
        model_frame(2); run_frame(2, 0, 1'b0); check_after(2);
        chk("after_abort_reg2", reg_q[23:16], 8'h7E);

        // Byte completed on the same edge ss deasserts is still committed
        tx_buf[0] = 8'h09; tx_buf[1] = 8'h3C;
        model_frame(2); run_frame(2, 0, 1'b1); check_after(2);

        // Reset mid-frame with ss held low: everything clears and no frame restarts
        ss = 1'b0; tick(4);
        spi_bits(8'h01, 8, 1'b0, rx, oa, oo);
        spi_bits(8'hFF, 4, 1'b0, rx, oa, oo);
        rst = 1'b1; tick(3); rst = 1'b0; tick(1);
        for (int i = 0; i < NR; i++) model[i] = 8'h00;
        chk("midrst_regs", reg_q, 0);
        chk("midrst_outs", {miso, oe, wr_valid, wr_addr, wr_data, busy}, 0);
        spi_bits(8'h01, 8, 1'b0, rx, oa, oo);
        spi_bits(8'hAB, 8, 1'b0, rx, oa, oo);
        chk("midrst_no_frame_busy", busy, 1'b0);
        chk("midrst_no_frame_regs", reg_q, 0);
        tick(4); ss = 1'b1; tick(12);
        tx_buf[0] = 8'h01;
        check_after(1);

        // Max-rate 32-byte burst from address 0
        tx_buf[0] = 8'h00;
        for (int i = 1; i <= 32; i++) tx_buf[i] = 8'($urandom);
        wc0 = wr_count;
        model_frame(33); run_frame(33, 0, 1'b0); check_after(33);
        chk("burst_pulses", wr_count - wc0, 32);

        // Random frames, with occasional trailing partial bytes
        for (int f = 0; f < 30; f++) begin
            n = $urandom_range(1, 5);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
            model_frame(n); run_frame(n, extra, 1'b0); check_after(n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
